// File: rtl/ex_stage_if.sv
// Bundle of the AZ execute stage: decoded instruction from ID, forwarding
// value back to ID, and the registered EX bundle toward MEM (and back to ID).
interface ex_stage_if;
    logic [29:0] id_pc;
    logic        id_en;
    logic [3:0]  id_alu_op;
    logic [31:0] id_alu_in_0;
    logic [31:0] id_alu_in_1;
    logic        id_br_flag;
    logic [1:0]  id_mem_op;
    logic [31:0] id_mem_wr_data;
    logic [1:0]  id_ctrl_op;
    logic [4:0]  id_dst_addr;
    logic        id_gpr_we_;
    logic [2:0]  id_exp_code;

    logic [31:0] fwd_data;

    logic [29:0] ex_pc;
    logic        ex_en;
    logic        ex_br_flag;
    logic [1:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data;
    logic [1:0]  ex_ctrl_op;
    logic [4:0]  ex_dst_addr;
    logic        ex_gpr_we_;
    logic [2:0]  ex_exp_code;
    logic [31:0] ex_out;

    modport master (
        output id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
               id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_,
               id_exp_code,
        input  fwd_data,
        input  ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
               ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
    );

    modport slave (
        input  id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_br_flag,
               id_mem_op, id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_,
               id_exp_code,
        output fwd_data,
        output ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
               ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
    );
endinterface

// File: rtl/ex_stage.sv
// AZ execute stage: ALU with signed-overflow detection, combinational
// forwarding, and the ID->EX pipeline register with stall/flush/interrupt.
module ex_stage (
    input  logic      clk,
    input  logic      reset,
    input  logic      stall,
    input  logic      flush,
    input  logic      int_detect,
    ex_stage_if.slave bus
);
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_ADDS = 4'd4,
        ALU_ADDU = 4'd5,
        ALU_SUBS = 4'd6,
        ALU_SUBU = 4'd7,
        ALU_SHRL = 4'd8,
        ALU_SHLL = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        EXP_NO_EXP   = 3'd0,
        EXP_OVERFLOW = 3'd3
    } exp_code_e;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  mem_op;
        logic [31:0] mem_wr_data;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } ex_bundle_t;

    localparam ex_bundle_t BUBBLE = '{
        pc:          '0,
        en:          1'b0,
        br_flag:     1'b0,
        mem_op:      '0,
        mem_wr_data: '0,
        ctrl_op:     '0,
        dst_addr:    '0,
        gpr_we_:     1'b1,
        exp_code:    EXP_NO_EXP,
        out:         '0
    };

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_out;
    logic        of;
    ex_bundle_t  ex_d;
    ex_bundle_t  ex_q;

    assign alu_a = bus.id_alu_in_0;
    assign alu_b = bus.id_alu_in_1;
    assign sum   = alu_a + alu_b;
    assign diff  = alu_a - alu_b;

    always_comb begin
        alu_out = '0;
        of      = 1'b0;
        case (bus.id_alu_op)
            ALU_NOP:  alu_out = alu_a;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_ADDS: begin
                alu_out = sum;
                of      = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            ALU_ADDU: alu_out = sum;
            ALU_SUBS: begin
                alu_out = diff;
                of      = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            ALU_SUBU: alu_out = diff;
            ALU_SHRL: alu_out = alu_a >> alu_b[4:0];
            ALU_SHLL: alu_out = alu_a << alu_b[4:0];
            default:  alu_out = '0;
        endcase
    end

    assign bus.fwd_data = alu_out;

    // Stall outranks flush/interrupt; an overflow replaces any incoming
    // exception code and suppresses the register write and memory access.
    always_comb begin
        ex_d = ex_q;
        if (!stall) begin
            if (flush || int_detect) begin
                ex_d = BUBBLE;
            end else begin
                ex_d.pc          = bus.id_pc;
                ex_d.en          = bus.id_en;
                ex_d.br_flag     = bus.id_br_flag;
                ex_d.mem_op      = bus.id_mem_op;
                ex_d.mem_wr_data = bus.id_mem_wr_data;
                ex_d.ctrl_op     = bus.id_ctrl_op;
                ex_d.dst_addr    = bus.id_dst_addr;
                ex_d.gpr_we_     = bus.id_gpr_we_;
                ex_d.exp_code    = bus.id_exp_code;
                ex_d.out         = alu_out;
                if (of && bus.id_en) begin
                    ex_d.exp_code = EXP_OVERFLOW;
                    ex_d.gpr_we_  = 1'b1;
                    ex_d.mem_op   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_pc          = ex_q.pc;
    assign bus.ex_en          = ex_q.en;
    assign bus.ex_br_flag     = ex_q.br_flag;
    assign bus.ex_mem_op      = ex_q.mem_op;
    assign bus.ex_mem_wr_data = ex_q.mem_wr_data;
    assign bus.ex_ctrl_op     = ex_q.ctrl_op;
    assign bus.ex_dst_addr    = ex_q.dst_addr;
    assign bus.ex_gpr_we_     = ex_q.gpr_we_;
    assign bus.ex_exp_code    = ex_q.exp_code;
    assign bus.ex_out         = ex_q.out;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    logic clk;
    logic reset;
    logic stall;
    logic flush;
    logic int_detect;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .int_detect (int_detect),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    // Expected contents of the EX register toward MEM.
    typedef struct {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  mem_op;
        logic [31:0] mem_wr_data;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } exp_t;

    exp_t m;

    function automatic void ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit of);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        of = 1'b0;
        r  = '0;
        case (op)
            0: r = a;
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4, 5: begin
                t = sa + sb;
                r = t[31:0];
                if (op == 4) of = (t > MAX_S) || (t < MIN_S);
            end
            6, 7: begin
                t = sa - sb;
                r = t[31:0];
                if (op == 6) of = (t > MAX_S) || (t < MIN_S);
            end
            8: r = a >> (b % 32);
            9: r = a << (b % 32);
            default: r = '0;
        endcase
    endfunction

    task automatic model_bubble();
        m.pc = '0; m.en = 1'b0; m.br_flag = 1'b0; m.mem_op = '0; m.mem_wr_data = '0;
        m.ctrl_op = '0; m.dst_addr = '0; m.gpr_we_ = 1'b1; m.exp_code = '0; m.out = '0;
    endtask

    task automatic model_clock();
        logic [31:0] r;
        bit          of;
        if (!reset) begin
            model_bubble();
        end else if (stall) begin
            // register holds
        end else if (flush || int_detect) begin
            model_bubble();
        end else begin
            ref_alu(int'(bus.id_alu_op), bus.id_alu_in_0, bus.id_alu_in_1, r, of);
            m.pc = bus.id_pc; m.en = bus.id_en; m.br_flag = bus.id_br_flag;
            m.mem_op = bus.id_mem_op; m.mem_wr_data = bus.id_mem_wr_data;
            m.ctrl_op = bus.id_ctrl_op; m.dst_addr = bus.id_dst_addr;
            m.gpr_we_ = bus.id_gpr_we_; m.exp_code = bus.id_exp_code; m.out = r;
            if (of && bus.id_en) begin
                m.exp_code = 3'd3;
                m.gpr_we_  = 1'b1;
                m.mem_op   = '0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       32'(bus.ex_pc),          32'(m.pc));
        check({tag, ".en"},       32'(bus.ex_en),          32'(m.en));
        check({tag, ".br"},       32'(bus.ex_br_flag),     32'(m.br_flag));
        check({tag, ".mem_op"},   32'(bus.ex_mem_op),      32'(m.mem_op));
        check({tag, ".wr_data"},  bus.ex_mem_wr_data,      m.mem_wr_data);
        check({tag, ".ctrl_op"},  32'(bus.ex_ctrl_op),     32'(m.ctrl_op));
        check({tag, ".dst"},      32'(bus.ex_dst_addr),    32'(m.dst_addr));
        check({tag, ".we_"},      32'(bus.ex_gpr_we_),     32'(m.gpr_we_));
        check({tag, ".exp"},      32'(bus.ex_exp_code),    32'(m.exp_code));
        check({tag, ".out"},      bus.ex_out,              m.out);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [6];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic set_id(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic en);
        bus.id_pc          = 30'($urandom);
        bus.id_en          = en;
        bus.id_alu_op      = op;
        bus.id_alu_in_0    = a;
        bus.id_alu_in_1    = b;
        bus.id_br_flag     = 1'($urandom);
        bus.id_mem_op      = 2'($urandom);
        bus.id_mem_wr_data = $urandom;
        bus.id_ctrl_op     = 2'($urandom);
        bus.id_dst_addr    = 5'($urandom);
        bus.id_gpr_we_     = 1'($urandom);
        bus.id_exp_code    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0;
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // forwarding path, clocks once, and checks the register contents.
    task automatic step(input string tag);
        logic [31:0] r;
        bit          of;
        #1;
        ref_alu(int'(bus.id_alu_op), bus.id_alu_in_0, bus.id_alu_in_1, r, of);
        check({tag, ".fwd"}, bus.fwd_data, r);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
        set_id(4'd0, 32'h0, 32'h0, 1'b0);
        model_bubble();
        @(negedge clk);
        #1 check_all("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // ADDS overflow suppresses write and memory op
        set_id(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b1);
        bus.id_gpr_we_ = 1'b0; bus.id_mem_op = 2'd2; bus.id_exp_code = 3'd0;
        step("adds_of");
        check("adds_of.out_c", bus.ex_out, 32'h8000_0000);
        check("adds_of.exp_c", 32'(bus.ex_exp_code), 32'd3);
        check("adds_of.we_c",  32'(bus.ex_gpr_we_), 32'd1);
        check("adds_of.mem_c", 32'(bus.ex_mem_op), 32'd0);

        set_id(4'd5, 32'hFFFF_FFFF, 32'h2, 1'b1);
        bus.id_exp_code = 3'd0;
        step("addu");
        check("addu.out_c", bus.ex_out, 32'h1);
        check("addu.exp_c", 32'(bus.ex_exp_code), 32'd0);

        set_id(4'd6, 32'h8000_0000, 32'h1, 1'b1);
        step("subs_of");
        check("subs_of.exp_c", 32'(bus.ex_exp_code), 32'd3);

        set_id(4'd8, 32'h8000_0000, 32'h24, 1'b1);
        step("shrl");
        check("shrl.out_c", bus.ex_out, 32'h0800_0000);

        // Overflow with id_en low: no exception substitution
        set_id(4'd4, 32'h8000_0000, 32'h8000_0000, 1'b0);
        bus.id_exp_code = 3'd5;
        step("of_noen");

        // Stall overrides flush
        set_id(4'd5, 32'd3, 32'd4, 1'b1);
        step("load7");
        check("load7.out_c", bus.ex_out, 32'd7);
        stall = 1'b1; flush = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            set_id(4'($urandom), $urandom, $urandom, 1'b1);
            step("stall_flush");
            check("stall_flush.out_c", bus.ex_out, 32'd7);
        end
        stall = 1'b0;
        step("flush");
        check("flush.en_c", 32'(bus.ex_en), 32'd0);
        flush = 1'b0;

        set_id(4'd2, $urandom, $urandom, 1'b1);
        bus.id_dst_addr = 5'd5;
        int_detect = 1'b1;
        step("int");
        check("int.en_c",  32'(bus.ex_en), 32'd0);
        check("int.dst_c", 32'(bus.ex_dst_addr), 32'd0);
        check("int.we_c",  32'(bus.ex_gpr_we_), 32'd1);
        int_detect = 1'b0;

        // Forwarding keeps tracking inputs while the register is stalled
        set_id(4'd1, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b1);
        step("pre_fwd");
        stall = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            bus.id_alu_in_0 = $urandom;
            bus.id_alu_op   = 4'($urandom_range(0, 9));
            step("fwd_stall");
        end
        stall = 1'b0;

        for (int unsigned i = 0; i < 400; i++) begin
            set_id(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), 1'($urandom_range(0, 3) != 0));
            stall      = ($urandom_range(0, 99) < 15);
            flush      = ($urandom_range(0, 99) < 10);
            int_detect = ($urandom_range(0, 99) < 5);
            step("rand");
        end
        stall = 1'b0; flush = 1'b0; int_detect = 1'b0;

        // Asynchronous reset in mid-cycle with a loaded register
        set_id(4'd3, $urandom, $urandom, 1'b1);
        step("pre_rst");
        set_id(4'($urandom), $urandom, $urandom, 1'b1);
        #2 reset = 1'b0;
        #1 model_bubble();
        check_all("rst_async");
        @(posedge clk);
        #1 check_all("rst_hold");
        @(negedge clk);
        reset = 1'b1;
        set_id(4'd9, 32'h1, 32'h1F, 1'b1);
        step("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
